// File: rtl/scytale_encryption.sv
// Streaming scytale cipher encoder: buffers plaintext until END_ENCRYPTION_TOKEN, then emits k*M mod (L-1) ordered ciphertext.
// Define SCYTALE_ENC_APPEND_TOKEN_EN to append START_DECRYPTION_TOKEN after the last ciphertext beat.
module scytale_encryption #(
  parameter int                   D_WIDTH                = 8,
  parameter int                   KEY_WIDTH              = 8,
  parameter int                   MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]   END_ENCRYPTION_TOKEN   = 8'hFA,
  parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy,
  output logic                 err_o
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int AW = $clog2(MAX_NOF_CHARS);
  localparam int PW = 2 * KEY_WIDTH;
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_NOF_CHARS);

`ifdef SCYTALE_ENC_APPEND_TOKEN_EN
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EMIT, S_TOKEN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EMIT} state_t;
`endif

  state_t                 r_state;
  logic [D_WIDTH-1:0]     r_buf [MAX_NOF_CHARS];
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          r_len;
  logic [KEY_WIDTH-1:0]   r_m;
  logic [CW-1:0]          r_k;
  logic [PW-1:0]          r_idx;
  logic [D_WIDTH-1:0]     r_data;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_err;

  logic [PW-1:0]          w_prod;
  logic                   w_store;
  logic [CW-1:0]          w_cur_k;
  logic [PW-1:0]          w_cur_idx;
  logic [PW-1:0]          w_lm1;
  logic [PW-1:0]          w_sum;
  logic [PW-1:0]          w_next_idx;
  logic                   w_last;
  logic [AW-1:0]          w_rd_addr;
  logic                   w_done;

  assign w_prod  = PW'(key_N) * PW'(key_M);
  assign w_store = (r_state == S_IDLE) && valid_i && (data_i != END_ENCRYPTION_TOKEN) && (r_count != MAX_C);

  // SETUP emits beat k=0 from idx=0 so the first character lands at T+2.
  assign w_cur_k    = (r_state == S_SETUP) ? '0 : r_k;
  assign w_cur_idx  = (r_state == S_SETUP) ? '0 : r_idx;
  assign w_lm1      = PW'(r_len) - PW'(1);
  assign w_sum      = w_cur_idx + PW'(r_m);
  assign w_next_idx = (w_sum >= w_lm1) ? (w_sum - w_lm1) : w_sum;
  assign w_last     = (w_cur_k == (r_len - ONE_C));
  assign w_rd_addr  = w_last ? AW'(r_len - ONE_C) : AW'(w_cur_idx);
  assign w_done     = (r_state == S_EMIT) && (r_k == r_len);

  always_ff @(posedge clk) begin
    if (w_store) r_buf[AW'(r_count)] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_len   <= '0;
      r_m     <= '0;
      r_k     <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i && (data_i == END_ENCRYPTION_TOKEN)) begin
            r_len   <= r_count;
            r_m     <= key_M;
            r_count <= '0;
            if ((r_count == '0) || (PW'(r_count) != w_prod)) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_busy  <= 1'b1;
            end
          end else if (w_store) begin
            r_count <= r_count + ONE_C;
          end
        end
        S_SETUP, S_EMIT: begin
          if (w_done) begin
`ifdef SCYTALE_ENC_APPEND_TOKEN_EN
            r_data  <= START_DECRYPTION_TOKEN;
            r_valid <= 1'b1;
            r_state <= S_TOKEN;
`else
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`endif
          end else begin
            r_data  <= r_buf[w_rd_addr];
            r_valid <= 1'b1;
            r_k     <= w_cur_k + ONE_C;
            r_idx   <= w_next_idx;
            r_state <= S_EMIT;
          end
        end
`ifdef SCYTALE_ENC_APPEND_TOKEN_EN
        S_TOKEN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
`endif
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign busy    = r_busy;
  assign err_o   = r_err;

endmodule

// File: tb/tb_scytale_encryption.sv
// Directed bench for scytale_encryption: hand-computed ciphertexts, reject paths, overflow, busy-input and reset cases.
module tb_scytale_encryption;

  typedef byte unsigned bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;
  logic       err_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  scytale_encryption dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy),
    .err_o   (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic drive_busy_input(input bit noise);
    if (noise) begin
      valid_i = 1'b1;
      data_i  = ($urandom_range(0, 3) == 0) ? 8'hFA : 8'(8'h41 + $urandom_range(0, 25));
    end else begin
      valid_i = 1'b0;
      data_i  = 8'h00;
    end
  endtask

  task automatic run_msg(input bq_t msg, input bq_t exp, input logic [7:0] n, input logic [7:0] m,
                         input bit exp_err, input bit noise);
    key_N = n;
    key_M = m;
    foreach (msg[i]) begin
      valid_i = 1'b1;
      data_i  = msg[i];
      step();
    end
    valid_i = 1'b1;
    data_i  = 8'hFA;
    step();
    valid_i = 1'b0;
    data_i  = 8'h00;
    if (exp_err) begin
      check("err_pulse", err_o, 1);
      check("err_busy", busy, 0);
      check("err_valid", valid_o, 0);
      step();
      check("err_clear", err_o, 0);
      check("err_valid2", valid_o, 0);
      check("err_busy2", busy, 0);
      return;
    end
    check("setup_busy", busy, 1);
    check("setup_valid", valid_o, 0);
    check("setup_err", err_o, 0);
    for (int k = 0; k < exp.size(); k++) begin
      drive_busy_input(noise);
      step();
      check($sformatf("ct_valid[%0d]", k), valid_o, 1);
      check($sformatf("ct_data[%0d]", k), data_o, exp[k]);
      check($sformatf("ct_busy[%0d]", k), busy, 1);
    end
`ifdef SCYTALE_ENC_APPEND_TOKEN_EN
    drive_busy_input(noise);
    step();
    check("tok_valid", valid_o, 1);
    check("tok_data", data_o, 8'hFA);
    check("tok_busy", busy, 1);
`endif
    drive_busy_input(noise);
    step();
    valid_i = 1'b0;
    data_i  = 8'h00;
    check("end_busy", busy, 0);
    check("end_valid", valid_o, 0);
    check("end_data", data_o, 0);
  endtask

  initial begin
    bq_t empty_q;
    bq_t big;
    bq_t big_exp;
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    key_N   = 8'h00;
    key_M   = 8'h00;
    step();
    step();
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_o, 0);
    rst = 1'b0;
    step();

    run_msg(str2q("ABCDEF"), str2q("ADBECF"), 8'd2, 8'd3, 1'b0, 1'b0);
    run_msg(str2q("ABCDEF"), str2q("ACEBDF"), 8'd3, 8'd2, 1'b0, 1'b0);
    run_msg(str2q("WXYZ"), str2q("WXYZ"), 8'd1, 8'd4, 1'b0, 1'b0);
    run_msg(str2q("ABCDE"), empty_q, 8'd2, 8'd3, 1'b1, 1'b0);
    run_msg(empty_q, empty_q, 8'd2, 8'd3, 1'b1, 1'b0);
    run_msg(str2q("Q"), str2q("Q"), 8'd1, 8'd1, 1'b0, 1'b0);

    // 55 characters, only the first 50 kept; order is k*10 mod 49 with the last beat fixed.
    for (int i = 0; i < 55; i++) big.push_back(8'(8'h21 + i));
    for (int k = 0; k < 49; k++) big_exp.push_back(big[(k * 10) % 49]);
    big_exp.push_back(big[49]);
    run_msg(big, big_exp, 8'd5, 8'd10, 1'b0, 1'b0);

    run_msg(str2q("ABCDEF"), str2q("ADBECF"), 8'd2, 8'd3, 1'b0, 1'b1);
    run_msg(str2q("ABCDEF"), str2q("ACEBDF"), 8'd3, 8'd2, 1'b0, 1'b0);

    key_N = 8'd2;
    key_M = 8'd3;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(8'h41 + i);
      step();
    end
    data_i = 8'hFA;
    step();
    valid_i = 1'b0;
    data_i  = 8'h00;
    step();
    step();
    check("pre_rst_valid", valid_o, 1);
    rst = 1'b1;
    step();
    check("mid_rst_data", data_o, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_o, 0);
    rst = 1'b0;
    run_msg(str2q("ABCDEF"), str2q("ADBECF"), 8'd2, 8'd3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
